// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low hex decode table,
// blank code and the decode helper.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry [n] is the active-low pattern for hex digit n (entry 0 is listed last).
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Refresh timing for the digit scan: per-slot counter, digit index, the dead-time
// flag at the start of each slot and the end-of-frame pulse.
module seg7_scan_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W      = $clog2(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_dead,
  output logic             o_wrap,
  output logic             o_frame_done
);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_fd;
  logic             w_tc;
  logic             w_last;

  assign w_tc   = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_last = (r_idx == IDX_W'(NUM_DIGITS - 1));
  // o_wrap marks the edge on which the index returns to 0
  assign o_wrap = i_enable & w_tc & w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_fd  <= 1'b0;
    end else begin
      r_fd <= o_wrap;
      if (!i_enable) begin
        r_cnt <= '0;
        r_idx <= '0;
      end else if (w_tc) begin
        r_cnt <= '0;
        r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_idx        = r_idx;
  assign o_dead       = (r_cnt < CNT_W'(DEAD_CYCLES));
  assign o_frame_done = r_fd & i_enable;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: shadow/display double buffer swapped only at frame
// wrap, leading-zero blanking, per-digit blink and registered active-low outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [IDX_W-1:0]        w_idx;
  logic                    w_dead;
  logic                    w_wrap;

  seg7_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (enable),
    .o_idx       (w_idx),
    .o_dead      (w_dead),
    .o_wrap      (w_wrap),
    .o_frame_done(frame_done)
  );

  logic [4*NUM_DIGITS-1:0] r_sh_val,   r_disp_val;
  logic [NUM_DIGITS-1:0]   r_sh_dp,    r_disp_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blink, r_disp_blink;
  logic                    r_pending;

  // A load on the wrap edge bypasses the shadow so that frame already shows it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_val     <= '0;
      r_sh_dp      <= '0;
      r_sh_blink   <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_disp_blink <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (load) begin
        r_sh_val   <= value;
        r_sh_dp    <= dp_in;
        r_sh_blink <= blink_mask;
      end
      if (w_wrap && load) begin
        r_disp_val   <= value;
        r_disp_dp    <= dp_in;
        r_disp_blink <= blink_mask;
        r_pending    <= 1'b0;
      end else if (w_wrap && r_pending) begin
        r_disp_val   <= r_sh_val;
        r_disp_dp    <= r_sh_dp;
        r_disp_blink <= r_sh_blink;
        r_pending    <= 1'b0;
      end else if (load) begin
        r_pending    <= 1'b1;
      end
    end
  end

  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_blink_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk_cnt     <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blk_cnt == BLK_W'(BLINK_CYCLES - 1)) begin
      r_blk_cnt     <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blk_cnt     <= r_blk_cnt + BLK_W'(1);
    end
  end

  logic [NUM_DIGITS-1:0] w_lz;
  logic                  w_zero_above;

  // Digit i is a leading zero when it and every higher nibble are zero.
  always_comb begin
    w_lz         = '0;
    w_zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_above = w_zero_above & (r_disp_val[4*i +: 4] == 4'h0);
      w_lz[i]      = w_zero_above & (i != 0);
    end
  end

  logic [3:0]            w_nib;
  logic [6:0]            w_seg;
  logic                  w_dpn;
  logic [NUM_DIGITS-1:0] w_an;

  always_comb begin
    w_nib = r_disp_val[{w_idx, 2'b00} +: 4];
    w_seg = seg7_decode(w_nib);
    w_dpn = ~r_disp_dp[w_idx];
    w_an  = w_dead ? '1 : ~(NUM_DIGITS'(1) << w_idx);
    if (blank_lz && w_lz[w_idx])
      w_seg = SEG_BLANK;
    if (r_blink_phase && r_disp_blink[w_idx]) begin
      w_seg = SEG_BLANK;
      w_dpn = 1'b1;
    end
    if (!enable) begin
      w_seg = SEG_BLANK;
      w_dpn = 1'b1;
      w_an  = '1;
    end
  end

  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg;
      r_dp  <= w_dpn;
      r_an  <= w_an;
    end
  end

  assign seg     = r_seg;
  assign dp      = r_dp;
  assign an      = r_an;
  assign pending = r_pending;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is held (legal >= 4).
REQ-003 SHALL have parameter DEAD_CYCLES, default 2, anti-ghost cycles at the start of each digit slot (legal < REFRESH_DIV).
REQ-004 SHALL have parameter BLINK_CYCLES, default 25000000, clock cycles per blink half-period (legal >= 1).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  1 = scan active; 0 = display dark.
REQ-008 load  in  1  one-cycle strobe capturing value, dp_in and blink_mask.
REQ-009 value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, digit 0 = least significant.
REQ-010 dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-011 blink_mask  in  NUM_DIGITS  1 = digit blinks.
REQ-012 blank_lz  in  1  1 = leading-zero blanking on (live, not captured).
REQ-013 seg  out  7  active-low segment code of the selected digit.
REQ-014 dp  out  1  active-low decimal point.
REQ-015 an  out  NUM_DIGITS  active-low one-hot digit select.
REQ-016 pending  out  1  captured data not yet on display.
REQ-017 frame_done  out  1  one-cycle pulse when the digit index wraps NUM_DIGITS-1 -> 0.

Function
REQ-018 Decode SHALL be 0:01 1:4F 2:12 3:06 4:4C 5:24 6:20 7:0F 8:00 9:04 A:08 B:60 C:31 D:42 E:30 F:38 (7-bit hex); blank SHALL be 7F.
REQ-019 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; at the terminal count the digit index SHALL advance, wrapping NUM_DIGITS-1 -> 0.
REQ-020 seg, dp and an SHALL be registered and SHALL reflect the new digit index one cycle after it changes.
REQ-021 While refresh count < DEAD_CYCLES, an SHALL be all ones; otherwise an SHALL drive bit[index] low and all other bits high.
REQ-022 load SHALL write into a shadow register and set pending; a load while pending is set SHALL overwrite the shadow register (last write wins).
REQ-023 At each index wrap to 0 with pending set, the shadow SHALL copy to the display register, pending SHALL clear, and the frame SHALL show the new data, so no frame mixes old and new digits.
REQ-024 A load in the same cycle as the wrap SHALL be copied straight to the display register, with pending left 0.
REQ-025 With blank_lz=1, digit i>0 SHALL be blanked when its nibble and all higher nibbles are 0; digit 0 SHALL never be blanked by this rule.
REQ-026 Leading-zero blanking SHALL NOT suppress dp.
REQ-027 The blink counter SHALL toggle blink_phase every BLINK_CYCLES cycles; with phase=1, masked digits SHALL output seg=7F and dp=1.
REQ-028 With enable=0, refresh count and index SHALL hold at 0, an SHALL be all ones, and load/pending SHALL still operate.
REQ-029 When enable goes 1, the scan SHALL start at digit 0, and the wrap transfer rule SHALL apply at its first wrap.
REQ-030 frame_done SHALL pulse only while enable=1.

Reset
REQ-031 During rst, outputs SHALL be seg=7F, dp=1, an all ones, pending=0 and frame_done=0.
REQ-032 During rst, counters, index, blink_phase, shadow register and display register SHALL all be 0.
REQ-033 rst asserted mid-frame SHALL force the reset values immediately; the scan SHALL resume at digit 0, count 0, on the first edge after release.

Structure
REQ-034 Package seg7_pkg SHALL hold the 16-entry decode constant table, the SEG_BLANK constant and a decode function.
REQ-035 Sub-module seg7_scan_timer SHALL contain the refresh counter, digit index, dead-time flag and frame_done generation.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, BLINK_CYCLES=32)
REQ-036 Reset then enable=1, load value=16'h12AF -> an cycles 1110,1101,1011,0111 with one dead cycle of 1111 in each slot; seg runs 38,08,12,4F after the first wrap.
REQ-037 blank_lz=1, value=16'h0050 -> digits 3 and 2 show 7F, digit 1 shows 24, digit 0 shows 01; value=0 -> only digit 0 shows 01.
REQ-038 Load 16'h1111 mid-frame, then 16'h2222 before the wrap -> pending=1 until the wrap; the next frame shows all 12, never a mix.
REQ-039 Load coinciding with the wrap cycle -> the new data appears in that frame, pending stays 0, frame_done pulses.
REQ-040 blink_mask=4'b0001, dp_in=4'b0010 -> digit 0 alternates data/7F every 32 cycles; digit 1 dp=0 steadily.
REQ-041 rst pulsed during digit 2 -> an=1111, seg=7F at once; after release the scan restarts at digit 0 and the display register reads 0.
